// File: rtl/apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// apu_frame_sequencer
//
// Frame counter for the APU channel set. Divides the CPU-rate APU clock into
// a quarter-frame strobe (~240 Hz) and a half-frame strobe (~120 Hz). These
// strobes clock the length, linear and envelope counters. The $4017 register
// selects 4-step or 5-step sequencing. A frame IRQ flag is read back through
// $4015.
//
// Optional feature macro: FRAME_IRQ_EN
//   defined   : frame IRQ flag, inhibit bit and the $4015 read clear exist.
//   undefined : frame_irq is tied low, status_read and reg_4017[6] are
//               ignored. Counter and strobe timing are unchanged.
//
// Ports:
//   clk             in   APU clock, all logic on rising edge
//   rst             in   synchronous reset, active-high, overrides all inputs
//   reg_4017[7:0]   in   frame counter register: [7] 5-step mode, [6] IRQ inhibit
//   reg_event_4017  in   one-cycle strobe, reg_4017 was just written
//   status_read     in   one-cycle strobe, CPU read of $4015 (clears IRQ flag)
//   enable_240hz    out  quarter-frame strobe, one cycle wide
//   enable_120hz    out  half-frame strobe, one cycle wide
//   frame_irq       out  frame interrupt flag, level
// -----------------------------------------------------------------------------
module apu_frame_sequencer #(
  parameter int unsigned STEP_Q1 = 7457,
  parameter int unsigned STEP_Q2 = 14913,
  parameter int unsigned STEP_Q3 = 22371,
  parameter int unsigned STEP_Q4 = 29829,
  parameter int unsigned STEP_Q5 = 37281,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reg_4017,
  input  logic       reg_event_4017,
  input  logic       status_read,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq
);

  localparam logic [CNT_W-1:0] Q1 = CNT_W'(STEP_Q1);
  localparam logic [CNT_W-1:0] Q2 = CNT_W'(STEP_Q2);
  localparam logic [CNT_W-1:0] Q3 = CNT_W'(STEP_Q3);
  localparam logic [CNT_W-1:0] Q4 = CNT_W'(STEP_Q4);
  localparam logic [CNT_W-1:0] Q5 = CNT_W'(STEP_Q5);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;     // 1 = 5-step sequence
  logic             e240_q, e240_d;
  logic             e120_q, e120_d;

  logic at_q1, at_q2, at_q3, at_q4, at_q5;
  logic at_wrap;

  assign at_q1 = (cnt_q == Q1);
  assign at_q2 = (cnt_q == Q2);
  assign at_q3 = (cnt_q == Q3);
  assign at_q4 = (cnt_q == Q4);
  assign at_q5 = (cnt_q == Q5);

  // The last step of the active sequence both wraps the counter and fires
  // both strobes; Q4 in 5-step mode is therefore silent.
  assign at_wrap = mode_q ? at_q5 : at_q4;

  // reg_4017[5:0] carry nothing for the frame sequencer.
  logic unused_low_bits;
  assign unused_low_bits = ^reg_4017[5:0];

  always_comb begin
    cnt_d  = at_wrap ? '0 : cnt_q + CNT_W'(1);
    mode_d = mode_q;
    e240_d = at_q1 | at_q2 | at_q3 | at_wrap;
    e120_d = at_q2 | at_wrap;
    // A write restarts the frame and replaces any step strobe of this edge;
    // selecting 5-step mode clocks the units immediately.
    if (reg_event_4017) begin
      cnt_d  = '0;
      mode_d = reg_4017[7];
      e240_d = reg_4017[7];
      e120_d = reg_4017[7];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      e240_q <= 1'b0;
      e120_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      e240_q <= e240_d;
      e120_q <= e120_d;
    end
  end

  assign enable_240hz = e240_q;
  assign enable_120hz = e120_q;

`ifdef FRAME_IRQ_EN
  logic inh_q, inh_d;
  logic irq_q, irq_d;
  logic irq_set;

  assign irq_set = at_q4 & ~mode_q & ~inh_q;

  // Priority, lowest first: status read clear, step set, write-with-inhibit
  // clear. Setting inhibit alone leaves a pending flag untouched.
  always_comb begin
    inh_d = inh_q;
    irq_d = irq_q;
    if (status_read) irq_d = 1'b0;
    if (irq_set)     irq_d = 1'b1;
    if (reg_event_4017) begin
      inh_d = reg_4017[6];
      if (reg_4017[6]) irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inh_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      inh_q <= inh_d;
      irq_q <= irq_d;
    end
  end

  assign frame_irq = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{status_read, reg_4017[6]};
  assign frame_irq = 1'b0;
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_apu_frame_sequencer
//
// Two instances share one stimulus stream: one with the default step counts
// and one with shortened steps so several frames fit in a short run. A
// timeline model (elapsed cycles since the last frame restart, compared with
// the step table of the active mode) predicts every output on every cycle.
// Honours FRAME_IRQ_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_apu_frame_sequencer;

  localparam int S_Q1 = 745;
  localparam int S_Q2 = 1491;
  localparam int S_Q3 = 2237;
  localparam int S_Q4 = 2982;
  localparam int S_Q5 = 3728;

  // clock / reset -------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] reg_4017;
  logic       reg_event_4017;
  logic       status_read;
  logic [1:0] e240, e120, irq;

  apu_frame_sequencer dut_full (
    .clk            (clk),
    .rst            (rst),
    .reg_4017       (reg_4017),
    .reg_event_4017 (reg_event_4017),
    .status_read    (status_read),
    .enable_240hz   (e240[0]),
    .enable_120hz   (e120[0]),
    .frame_irq      (irq[0])
  );

  apu_frame_sequencer #(
    .STEP_Q1 (S_Q1), .STEP_Q2 (S_Q2), .STEP_Q3 (S_Q3),
    .STEP_Q4 (S_Q4), .STEP_Q5 (S_Q5), .CNT_W (16)
  ) dut_small (
    .clk            (clk),
    .rst            (rst),
    .reg_4017       (reg_4017),
    .reg_event_4017 (reg_event_4017),
    .status_read    (status_read),
    .enable_240hz   (e240[1]),
    .enable_120hz   (e120[1]),
    .frame_irq      (irq[1])
  );

  // scoreboard ----------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model -----------------------------------------------------------
  int cyc = 0;          // rising edges seen so far
  int start [2];        // edge index at which the current frame saw count 0
  bit m_mode [2], m_inh [2], m_irq [2], x240 [2], x120 [2];
  bit armed = 1'b0;

  function automatic int step(input int k, input int n);
    int v;
    v = 0;
    if (k == 0) begin
      case (n)
        1: v = 7457;  2: v = 14913; 3: v = 22371;
        4: v = 29829; default: v = 37281;
      endcase
    end else begin
      case (n)
        1: v = S_Q1; 2: v = S_Q2; 3: v = S_Q3;
        4: v = S_Q4; default: v = S_Q5;
      endcase
    end
    return v;
  endfunction

  task automatic model_edge(input int k);
    int ph, last;
    bit set;
    ph   = cyc - start[k];
    last = m_mode[k] ? step(k, 5) : step(k, 4);
    set  = (ph == step(k, 4)) && !m_mode[k] && !m_inh[k];
    if (rst) begin
      start[k] = cyc + 1;
      m_mode[k] = 1'b0; m_inh[k] = 1'b0; m_irq[k] = 1'b0;
      x240[k] = 1'b0;   x120[k] = 1'b0;
    end else begin
      x240[k] = (ph == step(k, 1)) || (ph == step(k, 2)) ||
                (ph == step(k, 3)) || (ph == last);
      x120[k] = (ph == step(k, 2)) || (ph == last);
`ifdef FRAME_IRQ_EN
      if (set) m_irq[k] = 1'b1;
      else if (status_read) m_irq[k] = 1'b0;
`endif
      if (ph == last) start[k] = cyc + 1;
      if (reg_event_4017) begin
        start[k]  = cyc + 1;
        m_mode[k] = reg_4017[7];
        x240[k]   = reg_4017[7];
        x120[k]   = reg_4017[7];
`ifdef FRAME_IRQ_EN
        m_inh[k] = reg_4017[6];
        if (reg_4017[6]) m_irq[k] = 1'b0;
`endif
      end
    end
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
    cyc++;
  end

  always @(negedge clk) begin
    if (armed) begin
      check_bit("full_e240",  e240[0], x240[0]);
      check_bit("full_e120",  e120[0], x120[0]);
      check_bit("full_irq",   irq[0],  m_irq[0]);
      check_bit("small_e240", e240[1], x240[1]);
      check_bit("small_e120", e120[1], x120[1]);
      check_bit("small_irq",  irq[1],  m_irq[1]);
    end
  end

  // driver tasks --------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_reg(input logic [7:0] v);
    reg_4017       = v;
    reg_event_4017 = 1'b1;
    @(negedge clk);
    reg_event_4017 = 1'b0;
    reg_4017       = 8'($urandom);
  endtask

  task automatic read_status();
    status_read = 1'b1;
    @(negedge clk);
    status_read = 1'b0;
  endtask

  // Returns at the negedge before the edge that samples count == target.
  task automatic wait_phase(input int k, input int target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50000 && !found; i++) begin
      if (cyc - start[k] == target) found = 1'b1;
      else @(negedge clk);
    end
    check_bit("wait_phase", found, 1'b1);
  endtask

  // stimulus ------------------------------------------------------------------
  initial begin
    rst            = 1'b1;
    reg_4017       = 8'h00;
    reg_event_4017 = 1'b0;
    status_read    = 1'b0;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    rst   = 1'b0;

    // Free-running 4-step: one full default frame plus the IRQ rise.
    idle(29845);
    read_status();
    idle(5);

    // Status read coincident with the Q4 set edge: set wins.
    wait_phase(1, S_Q4);
    read_status();
    idle(3);
`ifdef FRAME_IRQ_EN
    check_bit("set_beats_read", irq[1], 1'b1);
`endif

    // Inhibit write while the flag is pending, then two quiet frames.
    write_reg(8'h40);
`ifdef FRAME_IRQ_EN
    check_bit("inhibit_write_clears", irq[1], 1'b0);
`endif
    idle(2 * (S_Q4 + 1) + 10);

    // Switch to 5-step at count 1000 and run past a whole 5-step frame.
    wait_phase(1, 1000);
    write_reg(8'h80);
    check_bit("immediate_240", e240[1], 1'b1);
    check_bit("immediate_120", e120[1], 1'b1);
    idle(S_Q5 + 1 + 20);

    // Reset for three cycles mid 5-step frame.
    wait_phase(1, 2000);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(S_Q1 + 10);

    // Writes coincident with step compares.
    wait_phase(1, S_Q2);
    write_reg(8'h00);
    check_bit("write_hides_q2", e240[1], 1'b0);
    wait_phase(1, S_Q4);
    idle(5);
    wait_phase(1, S_Q4);
    write_reg(8'h40);
    write_reg(8'h00);
    wait_phase(1, S_Q4);
    write_reg(8'hC0);
    idle(20);
    wait_phase(1, S_Q5);
    write_reg(8'h80);
    idle(10);

    // Random traffic.
    for (int i = 0; i < 12000; i++) begin
      rst            = ($urandom_range(0, 4999) == 0);
      status_read    = ($urandom_range(0, 99) < 3);
      reg_event_4017 = ($urandom_range(0, 1499) == 0);
      reg_4017       = 8'($urandom);
      @(negedge clk);
    end
    rst            = 1'b0;
    status_read    = 1'b0;
    reg_event_4017 = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
